// File: rtl/snn_pkg.sv
// Shared constants for the spiking-network core: SPI frame layout, slave FSM states
// and the configuration register address map.
package snn_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int ADDR_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Address map seen by the neuron array
  localparam logic [ADDR_W-1:0] ADDR_WEIGHT0 = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_THRESH  = 7'h08;
  localparam logic [ADDR_W-1:0] ADDR_LEAK    = 7'h0C;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 7'h0F;

  // Full-width compare so that high address bits are never aliased onto real registers
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int n);
    return int'(a) < n;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with optional rise/fall detect
// from a third flop; edges appear 2-3 clk after the pin toggles, no backpressure.
module sync_edge #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign dout = s2;

  generate
    if (EDGE) begin : g_edge
      logic s_d;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_d <= RST_VAL;
        else        s_d <= s2;
      end
      assign rise = s2 & ~s_d;
      assign fall = ~s2 & s_d;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/snn_spi_regfile.sv
// SPI mode-0 slave decoding 16-bit R/W frames into an 8-bit register bank.
// Writes land <=4 clk after the 16th sclk rise; the controller is never stalled.
module snn_spi_regfile
  import snn_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  copi,
  output logic                  cipo,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr
);

  localparam int CNT_W = 5;

  logic sclk_rise, sclk_fall, sclk_unused_lvl;
  logic cs_s, cs_unused_rise, cs_unused_fall;
  logic copi_s, copi_unused_rise, copi_unused_fall;

  sync_edge #(.RST_VAL(1'b0), .EDGE(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .dout(sclk_unused_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b1), .EDGE(1'b0)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .dout(cs_s), .rise(cs_unused_rise), .fall(cs_unused_fall)
  );
  sync_edge #(.RST_VAL(1'b0), .EDGE(1'b0)) u_copi_sync (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .dout(copi_s), .rise(copi_unused_rise), .fall(copi_unused_fall)
  );

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [6:0]        shift_in;
  logic [6:0]        shift_out;
  logic              rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        warm;
  logic              armed;
  logic [7:0]        regs [NUM_REGS];
  logic [7:0]        nxt;
  logic [7:0]        rd_dat;

  // Byte completed by the current rise: command byte at rise 8, data byte at rise 16
  assign nxt = {shift_in, copi_s};

  always_comb begin
    rd_dat = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (nxt[6:0] == ADDR_W'(k)) rd_dat = regs[k];
    end
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs_flat[8*k +: 8] = regs[k];
    end
  endgenerate

  // armed blocks a frame cut by reset from resuming: cs_n must be seen high once the
  // synchronizer holds real pin samples again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      rw        <= 1'b0;
      cmd_addr  <= '0;
      cipo      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      warm      <= '0;
      armed     <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_RESET;
    end else begin
      wr_strobe <= 1'b0;
      if (warm != 2'd2) warm <= warm + 2'd1;
      else if (cs_s)    armed <= 1'b1;

      case (state)
        IDLE: begin
          cnt  <= '0;
          cipo <= 1'b0;
          if (!cs_s && armed) state <= CMD;
        end
        CMD: begin
          if (cs_s) begin
            state <= IDLE;
            cnt   <= '0;
            cipo  <= 1'b0;
          end else if (sclk_rise) begin
            shift_in <= nxt[6:0];
            cnt      <= cnt + 1'b1;
            if (cnt == CNT_W'(CMD_BITS - 1)) begin
              rw       <= nxt[7];
              cmd_addr <= nxt[6:0];
              state    <= DATA;
              if (nxt[7]) begin
                shift_out <= '0;
                cipo      <= 1'b0;
              end else begin
                shift_out <= rd_dat[6:0];
                cipo      <= rd_dat[7];
              end
            end
          end
        end
        DATA: begin
          if (cs_s) begin
            state <= IDLE;
            cnt   <= '0;
            cipo  <= 1'b0;
          end else if (sclk_rise) begin
            shift_in <= nxt[6:0];
            cnt      <= cnt + 1'b1;
            if (cnt == CNT_W'(FRAME_BITS - 1)) begin
              state <= DONE;
              cipo  <= 1'b0;
              if (rw && addr_ok(cmd_addr, NUM_REGS)) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                  if (cmd_addr == ADDR_W'(k)) regs[k] <= nxt;
                end
                wr_strobe <= 1'b1;
                wr_addr   <= cmd_addr;
              end
            end
          end else if (sclk_fall) begin
            cipo      <= shift_out[6];
            shift_out <= {shift_out[5:0], 1'b0};
          end
        end
        DONE: begin
          cipo <= 1'b0;
          if (cs_s) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_spi_regfile.sv
// Directed and randomized SPI frames against an array model of the register bank.
module tb_snn_spi_regfile;

  localparam int NREGS = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sclk;
  logic             cs_n;
  logic             copi;
  logic             cipo;
  logic [NREGS*8-1:0] regs_flat;
  logic             wr_strobe;
  logic [6:0]       wr_addr;

  snn_spi_regfile #(.NUM_REGS(NREGS), .REG_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .copi(copi),
    .cipo(cipo), .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int strobe_hi = 0;
  logic strobe_prev = 1'b0;

  logic [7:0]         model [NREGS];
  logic [6:0]         model_wa;
  logic [NREGS*8-1:0] flat16;

  always @(negedge clk) begin
    if (wr_strobe) strobe_hi++;
    if (wr_strobe && !strobe_prev) strobe_cnt++;
    strobe_prev = wr_strobe;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NREGS*8-1:0] model_flat();
    logic [NREGS*8-1:0] f;
    for (int k = 0; k < NREGS; k++) f[8*k +: 8] = model[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    model_wa = 7'd0;
  endtask

  // Drives nbits sclk cycles; samples cipo 4 clk after rise 8 and falls 8..14.
  // rst_at > 0 pulses rst_n after that many bits while cs_n stays low.
  task automatic spi_frame(input logic [15:0] f, input int nbits, input int rst_at,
                           output logic [7:0] rd);
    rd = 8'h00;
    cs_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? f[15-i] : 1'($urandom);
      wait_clks(3);
      sclk = 1'b1;
      wait_clks(4);
      if (i == 7) rd[7] = cipo;
      if (i == 15) flat16 = regs_flat;
      wait_clks(2);
      sclk = 1'b0;
      wait_clks(4);
      if (i >= 7 && i <= 13) rd[13-i] = cipo;
      wait_clks(2);
      if (i + 1 == rst_at) begin
        rst_n = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
      end
    end
    wait_clks(4);
    cs_n = 1'b1;
    copi = 1'b0;
    wait_clks(8);
  endtask

  task automatic do_frame(input string tag, input logic [15:0] f, input int nbits);
    logic [7:0] rd;
    logic [6:0] a;
    logic       full;
    logic       valid;
    int         st0;
    int         exp_strobe;
    logic [7:0] exp_rd;
    st0   = strobe_cnt;
    spi_frame(f, nbits, 0, rd);
    a     = f[14:8];
    full  = (nbits >= 16);
    valid = (int'(a) < NREGS);
    exp_strobe = (full && f[15] && valid) ? 1 : 0;
    exp_rd     = (full && !f[15] && valid) ? model[a] : 8'h00;
    if (exp_strobe == 1) begin
      model[a] = f[7:0];
      model_wa = a;
    end
    check({tag, "_strobes"}, 128'(strobe_cnt - st0), 128'(exp_strobe));
    check({tag, "_wr_addr"}, 128'(wr_addr), 128'(model_wa));
    check({tag, "_regs"}, 128'(regs_flat), 128'(model_flat()));
    if (full) begin
      check({tag, "_cipo"}, 128'(rd), 128'(exp_rd));
      check({tag, "_latency"}, 128'(flat16), 128'(model_flat()));
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         st0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    copi  = 1'b0;
    model_reset();
    wait_clks(5);
    check("reset_regs_in", 128'(regs_flat), 128'(0));
    rst_n = 1'b1;
    wait_clks(6);
    check("reset_regs", 128'(regs_flat), 128'(0));
    check("reset_cipo", 128'(cipo), 128'(0));
    check("reset_strobe", 128'(wr_strobe), 128'(0));
    check("reset_wr_addr", 128'(wr_addr), 128'(0));
    check("reset_no_pulse", 128'(strobe_cnt), 128'(0));

    do_frame("wr5", 16'h85A5, 16);
    check("wr5_byte", 128'(regs_flat[47:40]), 128'(8'hA5));
    do_frame("rd5", 16'h0500, 16);

    do_frame("wr_oor", 16'hA0C3, 16);
    do_frame("rd_oor", 16'h2000, 16);

    do_frame("abort", 16'h8355, 12);
    do_frame("wr3", 16'h833C, 16);
    do_frame("rd3", 16'h0300, 16);

    do_frame("overlong", 16'h817E, 20);
    check("overlong_byte", 128'(regs_flat[15:8]), 128'(8'h7E));

    st0 = strobe_cnt;
    spi_frame(16'h8299, 16, 10, rd);
    model_reset();
    check("midrst_regs", 128'(regs_flat), 128'(model_flat()));
    check("midrst_strobes", 128'(strobe_cnt - st0), 128'(0));
    check("midrst_wr_addr", 128'(wr_addr), 128'(0));
    do_frame("after_rst", 16'h8211, 16);

    for (int n = 0; n < 24; n++) begin
      logic [15:0] f;
      f[15]   = 1'($urandom);
      f[14:8] = 7'($urandom_range(0, 31));
      f[7:0]  = 8'($urandom);
      do_frame("rand", f, 16);
    end

    check("strobe_width", 128'(strobe_hi), 128'(strobe_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_spi_regfile.md
# snn_spi_regfile

SPI slave and configuration register file for the spiking-network core. Serial pins from the chip inputs (sclk, cs_n, copi) are synchronized into the system clock domain and decoded into 16-bit read/write frames. Frames access a bank of 8-bit registers, such as weights, thresholds and leak values. The bank is presented as a flat bus to the neuron array, and read data is returned on cipo.

## Interface
Parameters:
- NUM_REGS, 16: number of 8-bit registers, 1..128.
- REG_RESET, 8'h00: reset value of every register.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock; asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
- cs_n  in  1  SPI chip select, active-low; asynchronous.
- copi  in  1  SPI controller-out data; asynchronous.
- cipo  out  1  SPI controller-in data; registered.
- regs_flat  out  NUM_REGS*8  register contents; reg k is at [8k+7:8k].
- wr_strobe  out  1  one-clk pulse when a register is written.
- wr_addr  out  7  address of the last write; valid while wr_strobe is high and held afterwards.

## Operation
- Synchronization:
  - sclk, cs_n and copi each pass through a 2-flop synchronizer.
  - A third flop on sclk gives rise = s & ~s_d and fall = ~s & s_d.
- Frame format, MSB first, 16 bits:
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data. Write data from the controller; don't-care on a read.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE:
  - bit counter = 0, cipo = 0.
  - Synchronized cs_n low → CMD.
- CMD:
  - On each rise, shift copi into shift_in and increment the counter.
  - At the 8th rise, latch rw and addr, then → DATA.
  - On a read, load shift_out in the same cycle with reg[addr], or 8'h00 if addr ≥ NUM_REGS.
  - cipo = shift_out[7] immediately after the load.
- DATA:
  - Each rise shifts copi in.
  - Each fall shifts shift_out left and drives the new MSB onto cipo.
  - At the 16th rise → DONE.
  - If rw = 1 and addr < NUM_REGS: write shift_in[7:0] to reg[addr], pulse wr_strobe and update wr_addr.
  - Out-of-range writes are dropped, with no strobe.
- DONE:
  - Further sclk edges are ignored and cipo = 0.
  - Synchronized cs_n high → IDLE.
- Abort: synchronized cs_n high in CMD or DATA → IDLE immediately. No write, no strobe, counter cleared.
- Writes and reads are 8-bit. Address bits above the range covered by NUM_REGS are compared, not truncated.
- cipo during a write frame: 0.

## Timing
- Reset values: regs_flat = {NUM_REGS{REG_RESET}}, cipo = 0, wr_strobe = 0, wr_addr = 0, FSM in IDLE, synchronizers cleared to sclk = 0, cs_n = 1, copi = 0.
- Reset asserted mid-frame clears everything. The frame in progress is lost even after rst_n is released; the controller must restart with a fresh cs_n low.
- Input-to-detect latency: 3 clk from a pin edge to rise or fall.
- Write latency:
  - The register updates and wr_strobe goes high on the clk edge following detection of the 16th rise, i.e. ≤ 4 clk after the pin edge.
  - wr_strobe lasts exactly 1 clk.
- Read: cipo is valid ≤ 4 clk after the 8th sclk pin rise, and ≤ 4 clk after each following sclk fall.
- Constraints on the controller:
  - sclk high and low phases each ≥ 4 clk, so f_sclk ≤ f_clk/8.
  - cs_n setup and hold to the first and last sclk edge ≥ 4 clk.
- Rise and cs_n deassertion detected in the same cycle: cs_n wins and the frame aborts.

## Structure
- Shared package snn_pkg:
  - Frame constants FRAME_BITS = 16, CMD_BITS = 8, ADDR_W = 7.
  - The FSM state enum.
  - Register address map constants used by the neuron core.
- Sub-module sync_edge: 2-flop synchronizer with an optional edge-detect output. Instantiated for sclk with edge detect, and for cs_n and copi without.
- Register bank, FSM and shift registers live in the top of this block.

## Test plan
- Reset: hold rst_n = 0, then release → every register reads 8'h00 on regs_flat, cipo = 0, no wr_strobe.
- Write then read: write frame 0x85A5 (addr 5, data 0xA5) → regs_flat[47:40] = 8'hA5, one wr_strobe with wr_addr = 5. Then read frame 0x0500 → cipo shifts out 1010_0101 on the 8 data bits.
- Out-of-range address with NUM_REGS = 16: write to addr 0x20 → no strobe, all registers unchanged. Read from addr 0x20 → cipo returns 0x00.
- Abort: raise cs_n after 12 sclk cycles of a write frame to addr 3 → reg 3 unchanged, no strobe. The next full frame writing 0x3C to addr 3 succeeds.
- Overlong frame: 20 sclk cycles writing addr 1 with data 0x7E → a single write of 0x7E, with extra bits ignored, until cs_n goes high.
- Reset mid-frame: assert rst_n low after bit 10 of a write to addr 2 → reg 2 = REG_RESET. The following clean frame writes correctly.
